// File: rtl/segment_reader.sv
// Recovers a 4-digit BCD frame from a multiplexed 7-segment bus.
// Each digit code must be stable for STABLE_CYCLES samples before capture.
//
// state    | meaning
// IDLE     | no slots filled
// FILLING  | 1-3 slots filled
// COMPLETE | all 4 slots filled; frame is handed off or dropped on next edge
module segment_reader #(
  parameter int unsigned STABLE_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [6:0]  din,
  input  logic [3:0]  dig_sel,
  output logic [15:0] dout,
  output logic        dout_err,
  output logic        dout_valid,
  input  logic        dout_ready,
  output logic        overrun
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    FILLING  = 2'd1,
    COMPLETE = 2'd2
  } fill_state_t;

  localparam logic [7:0] STABLE_C = 8'(STABLE_CYCLES);

  fill_state_t state;
  fill_state_t state_next;

  logic [3:0]  samp_sel;
  logic [6:0]  samp_seg;
  logic [7:0]  run_cnt;
  logic [7:0]  cnt_next;
  logic [15:0] slot_data;
  logic [15:0] data_next;
  logic [3:0]  filled;
  logic [3:0]  filled_next;
  logic [3:0]  slot_err;
  logic [3:0]  err_next;

  logic        changed;
  logic        one_hot;
  logic        capture;
  logic [3:0]  cap_mask;
  logic [3:0]  cap_nib;
  logic        cap_bad;
  logic        frame_done;
  logic        load;

  always_comb begin
    cap_bad = 1'b0;
    case (din)
      7'h3F:   cap_nib = 4'd0;
      7'h06:   cap_nib = 4'd1;
      7'h5B:   cap_nib = 4'd2;
      7'h4F:   cap_nib = 4'd3;
      7'h66:   cap_nib = 4'd4;
      7'h6D:   cap_nib = 4'd5;
      7'h7D:   cap_nib = 4'd6;
      7'h07:   cap_nib = 4'd7;
      7'h7F:   cap_nib = 4'd8;
      7'h6F:   cap_nib = 4'd9;
      default: begin
        cap_nib = 4'hF;
        cap_bad = 1'b1;
      end
    endcase
  end

  // Run counter compares the incoming sample against the registered one;
  // capture fires only on the edge the count first reaches the threshold.
  always_comb begin
    changed = ({dig_sel, din} != {samp_sel, samp_seg});
    if (changed)
      cnt_next = 8'd1;
    else if (run_cnt >= STABLE_C)
      cnt_next = STABLE_C;
    else
      cnt_next = run_cnt + 8'd1;

    one_hot  = (dig_sel != 4'd0) && ((dig_sel & (dig_sel - 4'd1)) == 4'd0);
    capture  = one_hot && (cnt_next == STABLE_C) && (changed || (run_cnt != STABLE_C));
    cap_mask = capture ? dig_sel : 4'd0;
  end

  // A capture coinciding with frame completion lands in the next frame,
  // so the clear is applied before the new slot bit is merged in.
  always_comb begin
    frame_done  = (state == COMPLETE);
    load        = frame_done && (!dout_valid || dout_ready);

    filled_next = (frame_done ? 4'd0 : filled) | cap_mask;
    err_next    = ((frame_done ? 4'd0 : slot_err) & ~cap_mask) |
                  (cap_bad ? cap_mask : 4'd0);

    data_next = slot_data;
    for (int i = 0; i < 4; i++) begin
      if (cap_mask[i])
        data_next[i*4 +: 4] = cap_nib;
    end

    if (&filled_next)
      state_next = COMPLETE;
    else if (|filled_next)
      state_next = FILLING;
    else
      state_next = IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      samp_sel   <= 4'd0;
      samp_seg   <= 7'd0;
      run_cnt    <= 8'd0;
      slot_data  <= 16'h0000;
      filled     <= 4'd0;
      slot_err   <= 4'd0;
      state      <= IDLE;
      dout       <= 16'h0000;
      dout_err   <= 1'b0;
      dout_valid <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      samp_sel  <= dig_sel;
      samp_seg  <= din;
      run_cnt   <= cnt_next;
      slot_data <= data_next;
      filled    <= filled_next;
      slot_err  <= err_next;
      state     <= state_next;
      overrun   <= frame_done && !load;

      if (load) begin
        dout       <= slot_data;
        dout_err   <= |slot_err;
        dout_valid <= 1'b1;
      end else if (dout_valid && dout_ready) begin
        dout_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_segment_reader.sv
// Scoreboard bench for segment_reader: expected frames are queued by the
// stimulus and popped by a monitor whenever a frame is accepted.
module tb_segment_reader;

  logic        clk;
  logic        rst_n;
  logic [6:0]  din;
  logic [3:0]  dig_sel;
  logic [15:0] dout;
  logic        dout_err;
  logic        dout_valid;
  logic        dout_ready;
  logic        overrun;

  int          checks;
  int          fails;
  int          ovr_cnt;
  logic [16:0] exp_q[$];

  segment_reader #(.STABLE_CYCLES(4)) u_dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .din        (din),
    .dig_sel    (dig_sel),
    .dout       (dout),
    .dout_err   (dout_err),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready),
    .overrun    (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Called at a falling edge; holds the code for n rising edges.
  task automatic drive(input logic [3:0] sel, input logic [6:0] code, input int n);
    dig_sel = sel;
    din     = code;
    repeat (n) @(negedge clk);
  endtask

  task automatic expect_frame(input logic err, input logic [15:0] val);
    exp_q.push_back({err, val});
  endtask

  // Monitor: frame accepted when valid and ready are both high before the edge.
  initial begin
    logic [16:0] e;
    forever begin
      @(negedge clk);
      #1;
      if (rst_n && dout_valid && dout_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          fails++;
          $display("FAIL unexpected_frame actual=%h err=%0d required=none", dout, dout_err);
        end else begin
          e = exp_q.pop_front();
          if ({dout_err, dout} !== e) begin
            fails++;
            $display("FAIL frame actual=%h err=%0d required=%h err=%0d",
                     dout, dout_err, e[15:0], e[16]);
          end
        end
      end
      if (rst_n && overrun) ovr_cnt++;
    end
  end

  initial begin
    checks     = 0;
    fails      = 0;
    ovr_cnt    = 0;
    rst_n      = 1'b0;
    dout_ready = 1'b1;
    din        = 7'd0;
    dig_sel    = 4'd0;

    // Reset with random bus activity
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      din     = 7'($urandom);
      dig_sel = 4'($urandom);
      chk("reset_dout", 32'(dout), 32'h0);
      chk("reset_valid", 32'(dout_valid), 32'h0);
      chk("reset_err", 32'(dout_err), 32'h0);
      chk("reset_overrun", 32'(overrun), 32'h0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    drive(4'b0000, 7'h00, 3);

    // Legal frame 1234 with latency check
    expect_frame(1'b0, 16'h1234);
    drive(4'b1000, 7'h06, 5);
    drive(4'b0100, 7'h5B, 5);
    drive(4'b0010, 7'h4F, 5);
    drive(4'b0001, 7'h66, 4);
    chk("legal_valid_at_capture", 32'(dout_valid), 32'h0);
    drive(4'b0001, 7'h66, 1);
    chk("legal_valid_rise", 32'(dout_valid), 32'h1);
    chk("legal_dout", 32'(dout), 32'h1234);
    drive(4'b0000, 7'h00, 1);
    chk("legal_valid_fall", 32'(dout_valid), 32'h0);
    chk("legal_dout_hold", 32'(dout), 32'h1234);
    drive(4'b0000, 7'h00, 2);

    // Glitch rejection on digit 2 inside an otherwise complete frame
    expect_frame(1'b0, 16'h1834);
    drive(4'b1000, 7'h06, 5);
    drive(4'b0010, 7'h4F, 5);
    drive(4'b0001, 7'h66, 5);
    drive(4'b0100, 7'h7F, 3);
    drive(4'b0100, 7'h6F, 2);
    for (int i = 0; i < 10; i++) begin
      drive(4'b0000, 7'h00, 1);
      chk("glitch_no_valid", 32'(dout_valid), 32'h0);
    end
    drive(4'b0100, 7'h7F, 4);
    drive(4'b0000, 7'h00, 4);

    // Illegal digit 1, then an all-legal frame clears the error
    expect_frame(1'b1, 16'h00F0);
    drive(4'b1000, 7'h3F, 5);
    drive(4'b0100, 7'h3F, 5);
    drive(4'b0010, 7'h00, 5);
    drive(4'b0001, 7'h3F, 5);
    drive(4'b0000, 7'h00, 3);
    expect_frame(1'b0, 16'h9876);
    drive(4'b1000, 7'h6F, 5);
    drive(4'b0100, 7'h7F, 5);
    drive(4'b0010, 7'h07, 5);
    drive(4'b0001, 7'h7D, 5);
    drive(4'b0000, 7'h00, 3);
    chk("legal_err_cleared", 32'(dout_err), 32'h0);

    // Backpressure: second frame is dropped with one overrun pulse
    dout_ready = 1'b0;
    expect_frame(1'b0, 16'h5678);
    drive(4'b1000, 7'h6D, 5);
    drive(4'b0100, 7'h7D, 5);
    drive(4'b0010, 7'h07, 5);
    drive(4'b0001, 7'h7F, 5);
    drive(4'b0000, 7'h00, 2);
    chk("bp_valid_held", 32'(dout_valid), 32'h1);
    drive(4'b1000, 7'h6F, 5);
    drive(4'b0100, 7'h3F, 5);
    drive(4'b0010, 7'h06, 5);
    drive(4'b0001, 7'h5B, 5);
    drive(4'b0000, 7'h00, 3);
    chk("bp_dout_kept", 32'(dout), 32'h5678);
    chk("bp_valid_kept", 32'(dout_valid), 32'h1);
    chk("bp_overrun_once", 32'(ovr_cnt), 32'h1);
    dout_ready = 1'b1;
    drive(4'b0000, 7'h00, 1);
    chk("bp_valid_fall", 32'(dout_valid), 32'h0);
    chk("bp_dout_after_accept", 32'(dout), 32'h5678);
    drive(4'b0000, 7'h00, 2);

    // Reset mid-frame discards digits 0 and 1
    drive(4'b0001, 7'h07, 5);
    drive(4'b0010, 7'h07, 5);
    rst_n = 1'b0;
    drive(4'b0000, 7'h00, 2);
    chk("midrst_dout", 32'(dout), 32'h0);
    chk("midrst_valid", 32'(dout_valid), 32'h0);
    rst_n = 1'b1;
    expect_frame(1'b0, 16'h5023);
    drive(4'b0100, 7'h3F, 5);
    drive(4'b1000, 7'h6D, 5);
    for (int i = 0; i < 6; i++) begin
      drive(4'b0000, 7'h00, 1);
      chk("midrst_no_valid", 32'(dout_valid), 32'h0);
    end
    drive(4'b0001, 7'h4F, 5);
    drive(4'b0010, 7'h5B, 5);
    drive(4'b0000, 7'h00, 5);

    chk("frames_all_seen", 32'(exp_q.size()), 32'h0);
    chk("overrun_total", 32'(ovr_cnt), 32'h1);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
